// File: rtl/tick_pkg.sv
// Shared definitions for the tick divider/monitor family: state encodings,
// default timing constants and the flag bundle passed from the interval
// counter to the monitor state machine.
package tick_pkg;

  // Default nominal tick interval and allowed deviation, in clock cycles.
  localparam logic [31:0] DEF_EXPECTED   = 32'd1000000;
  localparam logic [31:0] DEF_TOL        = 32'd16;
  localparam int unsigned DEF_LOCK_COUNT = 4;

  // Monitor state encodings.
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ACQUIRE = 2'd1;
  localparam logic [1:0] ST_LOCKED  = 2'd2;
  localparam logic [1:0] ST_FAULT   = 2'd3;

  // Per-cycle classification of the interval that would end on this cycle.
  typedef struct packed {
    logic in_window;  // tick interval within [EXPECTED-TOL, EXPECTED+TOL]
    logic early;      // tick interval below EXPECTED-TOL
    logic overdue;    // no tick on the last in-window cycle of this gap
  } interval_flags_t;

  // 8-bit increment that sticks at all-ones.
  function automatic logic [7:0] sat_inc8(input logic [7:0] value);
    return (value == 8'hFF) ? value : value + 8'd1;
  endfunction

endpackage

// File: rtl/tick_interval_counter.sv
// Saturating cycle counter between ticks, plus the window compare that
// classifies each interval and the once-per-gap overdue detector.
module tick_interval_counter
  import tick_pkg::*;
#(
  parameter logic [31:0] EXPECTED = DEF_EXPECTED,
  parameter logic [31:0] TOL      = DEF_TOL
) (
  input  logic            cin,
  input  logic            reset,
  input  logic            i_tick,
  output logic [31:0]     o_interval,
  output interval_flags_t o_flags
);

  localparam logic [31:0] WIN_LO     = EXPECTED - TOL;
  localparam logic [31:0] WIN_HI     = EXPECTED + TOL;
  // Last count value at which a tick still lands inside the window.
  localparam logic [31:0] OVERDUE_AT = WIN_HI - 32'd1;

  logic [31:0] r_cnt;
  logic        r_overdue;

  logic [31:0] w_interval;
  logic        w_overdue;

  // Interval as seen if a tick lands this cycle, and the overdue strobe.
  always_comb begin
    w_interval = (r_cnt == '1) ? r_cnt : r_cnt + 32'd1;
    w_overdue  = !i_tick && (r_cnt == OVERDUE_AT) && !r_overdue;
  end

  // Counter clears on a tick, otherwise counts up and holds at all-ones;
  // the overdue flag suppresses repeat detections until the next tick.
  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of block evaluation order.
  always_ff @(posedge cin) begin
    if (reset) begin
      r_cnt     <= '0;
      r_overdue <= 1'b0;
    end else if (i_tick) begin
      r_cnt     <= '0;
      r_overdue <= 1'b0;
    end else begin
      if (r_cnt != '1) r_cnt <= r_cnt + 32'd1;
      if (w_overdue)   r_overdue <= 1'b1;
    end
  end

  // Window classification of the candidate interval.
  always_comb begin
    o_interval        = w_interval;
    o_flags.in_window = (w_interval >= WIN_LO) && (w_interval <= WIN_HI);
    o_flags.early     = (w_interval < WIN_LO);
    o_flags.overdue   = w_overdue;
  end

endmodule

// File: rtl/tick_monitor.sv
// Tick health monitor: measures tick-to-tick intervals, acquires lock after
// a run of in-window intervals, and flags early or missing ticks once locked.
module tick_monitor
  import tick_pkg::*;
#(
  parameter logic [31:0] EXPECTED   = DEF_EXPECTED,
  parameter logic [31:0] TOL        = DEF_TOL,
  parameter int unsigned LOCK_COUNT = DEF_LOCK_COUNT
) (
  input  logic        cin,
  input  logic        reset,
  input  logic        tick_in,
  output logic [31:0] period,
  output logic        locked,
  output logic        fault_early,
  output logic        fault_missing,
  output logic [7:0]  err_count
);

  localparam logic [3:0] LOCK_CNT4 = 4'(LOCK_COUNT);

  logic [31:0]     w_interval;
  interval_flags_t w_flags;

  logic [1:0]  r_state;
  logic [3:0]  r_good_run;
  logic [31:0] r_period;
  logic        r_locked;
  logic        r_fault_early;
  logic        r_fault_missing;
  logic [7:0]  r_err_count;

  logic [1:0]  w_state_nxt;
  logic [3:0]  w_good_run_nxt;
  logic        w_early_pulse;
  logic        w_missing_pulse;
  logic [3:0]  w_good_run_inc;

  tick_interval_counter #(
    .EXPECTED (EXPECTED),
    .TOL      (TOL)
  ) u_counter (
    .cin        (cin),
    .reset      (reset),
    .i_tick     (tick_in),
    .o_interval (w_interval),
    .o_flags    (w_flags)
  );

  // Next-state and fault-pulse decode for the lock state machine.
  // NOTE: every output of this block is given a default first, so no path
  // leaves a variable unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt     = r_state;
    w_good_run_nxt  = r_good_run;
    w_early_pulse   = 1'b0;
    w_missing_pulse = 1'b0;
    w_good_run_inc  = r_good_run + 4'd1;

    case (r_state)
      ST_IDLE: begin
        if (tick_in) begin
          w_state_nxt    = ST_ACQUIRE;
          w_good_run_nxt = '0;
        end
      end

      ST_ACQUIRE: begin
        if (tick_in) begin
          if (w_flags.in_window) begin
            w_good_run_nxt = w_good_run_inc;
            if (w_good_run_inc >= LOCK_CNT4) w_state_nxt = ST_LOCKED;
          end else begin
            w_good_run_nxt = '0;
          end
        end else if (w_flags.overdue) begin
          // A gap that has run past the window breaks the run silently.
          w_good_run_nxt = '0;
        end
      end

      ST_LOCKED: begin
        if (tick_in && w_flags.early) begin
          w_state_nxt   = ST_FAULT;
          w_early_pulse = 1'b1;
        end else if (w_flags.overdue) begin
          w_state_nxt     = ST_FAULT;
          w_missing_pulse = 1'b1;
        end
      end

      ST_FAULT: begin
        if (tick_in) begin
          w_state_nxt    = ST_ACQUIRE;
          w_good_run_nxt = '0;
        end
      end

      default: begin
        w_state_nxt    = ST_IDLE;
        w_good_run_nxt = '0;
      end
    endcase
  end

  // State, run length and registered outputs; reset wins over a coincident tick.
  always_ff @(posedge cin) begin
    if (reset) begin
      r_state         <= ST_IDLE;
      r_good_run      <= '0;
      r_period        <= '0;
      r_locked        <= 1'b0;
      r_fault_early   <= 1'b0;
      r_fault_missing <= 1'b0;
      r_err_count     <= '0;
    end else begin
      r_state         <= w_state_nxt;
      r_good_run      <= w_good_run_nxt;
      r_locked        <= (w_state_nxt == ST_LOCKED);
      r_fault_early   <= w_early_pulse;
      r_fault_missing <= w_missing_pulse;
      // The first tick after reset only starts the measurement.
      if (tick_in && (r_state != ST_IDLE)) r_period <= w_interval;
      if (w_early_pulse || w_missing_pulse) r_err_count <= sat_inc8(r_err_count);
    end
  end

  // Outputs come straight from flops.
  assign period        = r_period;
  assign locked        = r_locked;
  assign fault_early   = r_fault_early;
  assign fault_missing = r_fault_missing;
  assign err_count     = r_err_count;

endmodule

// File: tb/tb_tick_monitor.sv
// Scoreboard bench for tick_monitor with EXPECTED=10, TOL=2, LOCK_COUNT=3.
// The driver queues the hand-computed response for each tick or fault; the
// monitor pops and compares whenever the DUT responds.
module tb_tick_monitor;
  import tick_pkg::*;

  typedef struct packed {
    logic [31:0] period;
    logic        locked;
    logic        early;
    logic        missing;
    logic [7:0]  err;
    logic [1:0]  state;
    logic [3:0]  good_run;
  } obs_t;

  logic        cin = 1'b0;
  logic        reset = 1'b1;
  logic        tick_in = 1'b0;
  logic [31:0] period;
  logic        locked;
  logic        fault_early;
  logic        fault_missing;
  logic [7:0]  err_count;

  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   last_tick_cyc = 0;
  logic tick_seen = 1'b0;

  obs_t  exp_q[$];
  int    cyc_q[$];
  string tag_q[$];

  tick_monitor #(
    .EXPECTED   (32'd10),
    .TOL        (32'd2),
    .LOCK_COUNT (3)
  ) dut (
    .cin           (cin),
    .reset         (reset),
    .tick_in       (tick_in),
    .period        (period),
    .locked        (locked),
    .fault_early   (fault_early),
    .fault_missing (fault_missing),
    .err_count     (err_count)
  );

  always #5 cin = ~cin;

  // Edge counter and record of which edges sampled a tick.
  always @(posedge cin) begin
    cyc       <= cyc + 1;
    tick_seen <= tick_in;
    if (tick_in) last_tick_cyc <= cyc + 1;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic obs_t mk(input logic [31:0] p, input logic l, input logic e,
                              input logic m, input logic [7:0] err,
                              input logic [1:0] st, input logic [3:0] gr);
    obs_t o;
    o.period = p; o.locked = l; o.early = e; o.missing = m;
    o.err = err; o.state = st; o.good_run = gr;
    return o;
  endfunction

  // Issue a tick sampled n edges after the previous tick edge.
  task automatic tick(input int n, input obs_t e, input string tag);
    exp_q.push_back(e);
    cyc_q.push_back(-1);
    tag_q.push_back(tag);
    repeat (n - 1) @(posedge cin);
    #1 tick_in = 1'b1;
    @(posedge cin);
    #1 tick_in = 1'b0;
  endtask

  // Expect a missing-tick pulse exactly 12 edges after the last tick edge.
  task automatic expect_missing(input obs_t e, input string tag);
    exp_q.push_back(e);
    cyc_q.push_back(last_tick_cyc + 12);
    tag_q.push_back(tag);
  endtask

  // Reset and tick asserted in the same cycle.
  task automatic reset_with_tick(input obs_t e, input string tag);
    exp_q.push_back(e);
    cyc_q.push_back(-1);
    tag_q.push_back(tag);
    reset = 1'b1;
    tick_in = 1'b1;
    @(posedge cin);
    #1 reset = 1'b0;
    tick_in = 1'b0;
  endtask

  // Monitor: compare every DUT response against the next queued expectation.
  initial begin
    obs_t  e;
    obs_t  a;
    int    ec;
    string tg;
    forever begin
      @(negedge cin);
      if (tick_seen || fault_early || fault_missing) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_output: cycle %0d early=%b missing=%b, no response expected",
                   cyc, fault_early, fault_missing);
        end else begin
          e  = exp_q.pop_front();
          ec = cyc_q.pop_front();
          tg = tag_q.pop_front();
          a  = mk(period, locked, fault_early, fault_missing, err_count,
                  dut.r_state, dut.r_good_run);
          check({tg, ".period"},   64'(a.period),   64'(e.period));
          check({tg, ".locked"},   64'(a.locked),   64'(e.locked));
          check({tg, ".early"},    64'(a.early),    64'(e.early));
          check({tg, ".missing"},  64'(a.missing),  64'(e.missing));
          check({tg, ".err"},      64'(a.err),      64'(e.err));
          check({tg, ".state"},    64'(a.state),    64'(e.state));
          check({tg, ".good_run"}, 64'(a.good_run), 64'(e.good_run));
          if (ec >= 0) check({tg, ".cycle"}, 64'(cyc), 64'(ec));
        end
      end
    end
  end

  // Driver: directed scenarios with hand-computed responses.
  initial begin
    int ee;
    repeat (3) @(posedge cin);
    #1;
    check("rst.period",        64'(period),        64'd0);
    check("rst.locked",        64'(locked),        64'd0);
    check("rst.fault_early",   64'(fault_early),   64'd0);
    check("rst.fault_missing", 64'(fault_missing), 64'd0);
    check("rst.err_count",     64'(err_count),     64'd0);
    check("rst.state",         64'(dut.r_state),   64'(ST_IDLE));
    reset = 1'b0;

    // Lock-up: first tick only starts measuring, then three good intervals.
    tick(1,  mk(32'd0,  0, 0, 0, 8'd0, ST_ACQUIRE, 4'd0), "lock_t1");
    tick(10, mk(32'd10, 0, 0, 0, 8'd0, ST_ACQUIRE, 4'd1), "lock_t2");
    tick(10, mk(32'd10, 0, 0, 0, 8'd0, ST_ACQUIRE, 4'd2), "lock_t3");
    tick(10, mk(32'd10, 1, 0, 0, 8'd0, ST_LOCKED,  4'd3), "lock_t4");

    // Early fault from LOCKED.
    tick(7,  mk(32'd7,  0, 1, 0, 8'd1, ST_FAULT,   4'd3), "early");

    // Window edges while acquiring.
    tick(10, mk(32'd10, 0, 0, 0, 8'd1, ST_ACQUIRE, 4'd0), "win_restart");
    tick(8,  mk(32'd8,  0, 0, 0, 8'd1, ST_ACQUIRE, 4'd1), "win_lo_in");
    tick(12, mk(32'd12, 0, 0, 0, 8'd1, ST_ACQUIRE, 4'd2), "win_hi_in");
    tick(13, mk(32'd13, 0, 0, 0, 8'd1, ST_ACQUIRE, 4'd0), "win_hi_out");
    tick(12, mk(32'd12, 0, 0, 0, 8'd1, ST_ACQUIRE, 4'd1), "win_hi_in2");
    tick(7,  mk(32'd7,  0, 0, 0, 8'd1, ST_ACQUIRE, 4'd0), "win_lo_out");
    tick(8,  mk(32'd8,  0, 0, 0, 8'd1, ST_ACQUIRE, 4'd1), "win_lo_in2");
    tick(12, mk(32'd12, 0, 0, 0, 8'd1, ST_ACQUIRE, 4'd2), "win_hi_in3");
    tick(10, mk(32'd10, 1, 0, 0, 8'd1, ST_LOCKED,  4'd3), "win_relock");

    // Missing tick, then a late tick that must not pulse again.
    expect_missing(mk(32'd10, 0, 0, 1, 8'd2, ST_FAULT, 4'd3), "missing");
    tick(20, mk(32'd20, 0, 0, 0, 8'd2, ST_ACQUIRE, 4'd0), "late_tick");
    tick(10, mk(32'd10, 0, 0, 0, 8'd2, ST_ACQUIRE, 4'd1), "relock_t1");
    tick(10, mk(32'd10, 0, 0, 0, 8'd2, ST_ACQUIRE, 4'd2), "relock_t2");
    tick(10, mk(32'd10, 1, 0, 0, 8'd2, ST_LOCKED,  4'd3), "relock_t3");

    // Reset collides with an (early) tick while LOCKED.
    reset_with_tick(mk(32'd0, 0, 0, 0, 8'd0, ST_IDLE, 4'd0), "rst_collide");
    tick(5,  mk(32'd0,  0, 0, 0, 8'd0, ST_ACQUIRE, 4'd0), "post_rst_first");
    tick(10, mk(32'd10, 0, 0, 0, 8'd0, ST_ACQUIRE, 4'd1), "post_rst_t2");
    tick(10, mk(32'd10, 0, 0, 0, 8'd0, ST_ACQUIRE, 4'd2), "post_rst_t3");
    tick(10, mk(32'd10, 1, 0, 0, 8'd0, ST_LOCKED,  4'd3), "post_rst_t4");

    // Saturation: repeated early fault / relock cycles.
    for (int i = 0; i < 300; i++) begin
      ee = (i + 1 > 255) ? 255 : i + 1;
      tick(7,  mk(32'd7,  0, 1, 0, 8'(ee), ST_FAULT,   4'd3), "sat_early");
      tick(10, mk(32'd10, 0, 0, 0, 8'(ee), ST_ACQUIRE, 4'd0), "sat_restart");
      tick(10, mk(32'd10, 0, 0, 0, 8'(ee), ST_ACQUIRE, 4'd1), "sat_g1");
      tick(10, mk(32'd10, 0, 0, 0, 8'(ee), ST_ACQUIRE, 4'd2), "sat_g2");
      tick(10, mk(32'd10, 1, 0, 0, 8'(ee), ST_LOCKED,  4'd3), "sat_g3");
    end

    repeat (3) @(posedge cin);
    #1;
    check("err_saturated", 64'(err_count),    64'd255);
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
